// File: rtl/tx_qpc_requester.sv
// Send-queue requester: looks up the QP context, sizes the message in packets,
// advances PSN/MSN and emits a header descriptor. Option: QPC_LOOKUP_TIMEOUT_EN.
module tx_qpc_requester #(
   parameter int MAX_QP       = 256,
   parameter int QP_PTR_WIDTH = $clog2(MAX_QP)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_wqe_valid,
   output logic                    o_wqe_ready,
   input  logic [QP_PTR_WIDTH-1:0] i_wqe_qp_id,
   input  logic [31:0]             i_wqe_len,
   output logic                    o_qpc_hdr_lookup_valid,
   input  logic                    i_qpc_hdr_lookup_ready,
   output logic [QP_PTR_WIDTH-1:0] o_qpc_hdr_lookup_qp_id,
   input  logic                    i_qpc_valid,
   input  logic [2:0]              i_qpc_pmtu,
   input  logic [23:0]             i_qpc_dest_qpid,
   input  logic [23:0]             i_qpc_sq_curr_psn,
   input  logic [23:0]             i_qpc_sq_curr_msn,
   output logic                    o_qpc_hdr_update_valid,
   output logic [QP_PTR_WIDTH-1:0] o_qpc_hdr_update_qpid,
   output logic [23:0]             o_qpc_sq_curr_psn,
   output logic [23:0]             o_qpc_sq_curr_msn,
   output logic                    o_hdr_valid,
   input  logic                    i_hdr_ready,
   output logic [QP_PTR_WIDTH-1:0] o_hdr_qp_id,
   output logic [23:0]             o_hdr_dest_qpid,
   output logic [23:0]             o_hdr_first_psn,
   output logic [24:0]             o_hdr_pkt_cnt,
   output logic [23:0]             o_hdr_msn,
   output logic [1:0]              o_hdr_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_CALC   = 3'd3;
   localparam logic [2:0] S_UPDATE = 3'd4;
   localparam logic [2:0] S_OUT    = 3'd5;

   logic [2:0]              state;
   logic [QP_PTR_WIDTH-1:0] qp_id;
   logic [31:0]             len;
   logic [2:0]              pmtu;
   logic [23:0]             dest_qpid;
   logic [23:0]             psn;
   logic [23:0]             msn;
   logic [23:0]             new_psn;
   logic [23:0]             new_msn;
   logic [24:0]             pkt_cnt;
   logic [1:0]              err;
   logic                    pmtu_ok;
   logic [4:0]              shift;
   logic [31:0]             mask;
   logic [24:0]             cnt_calc;
`ifdef QPC_LOOKUP_TIMEOUT_EN
   logic [4:0]              tmo_cnt;
`endif

   // MTU is 2^(pmtu+7) bytes, so ceil(len/mtu) is a shift plus a remainder bit
   always_comb begin
      pmtu_ok  = (pmtu >= 3'd1) && (pmtu <= 3'd5);
      shift    = {2'b00, pmtu} + 5'd7;
      mask     = ~(32'hFFFF_FFFF << shift);
      cnt_calc = 25'(len >> shift) + 25'(|(len & mask));
      if (len == 32'd0)
         cnt_calc = 25'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         qp_id     <= '0;
         len       <= '0;
         pmtu      <= '0;
         dest_qpid <= '0;
         psn       <= '0;
         msn       <= '0;
         new_psn   <= '0;
         new_msn   <= '0;
         pkt_cnt   <= '0;
         err       <= '0;
`ifdef QPC_LOOKUP_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         unique case (state)
            S_IDLE: if (i_wqe_valid) begin
               qp_id     <= i_wqe_qp_id;
               len       <= i_wqe_len;
               dest_qpid <= '0;
               psn       <= '0;
               msn       <= '0;
               pkt_cnt   <= '0;
               err       <= '0;
               state     <= S_LOOKUP;
            end
            S_LOOKUP: if (i_qpc_hdr_lookup_ready) begin
`ifdef QPC_LOOKUP_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_qpc_valid) begin
                  pmtu      <= i_qpc_pmtu;
                  dest_qpid <= i_qpc_dest_qpid;
                  psn       <= i_qpc_sq_curr_psn;
                  msn       <= i_qpc_sq_curr_msn;
                  state     <= S_CALC;
               end
`ifdef QPC_LOOKUP_TIMEOUT_EN
               else if (tmo_cnt == 5'd31) begin
                  err   <= 2'b10;
                  state <= S_OUT;
               end else begin
                  tmo_cnt <= tmo_cnt + 5'd1;
               end
`endif
            end
            S_CALC: begin
               if (pmtu_ok) begin
                  pkt_cnt <= cnt_calc;
                  new_psn <= psn + cnt_calc[23:0];
                  new_msn <= msn + 24'd1;
                  state   <= S_UPDATE;
               end else begin
                  err   <= 2'b01;
                  state <= S_OUT;
               end
            end
            S_UPDATE: state <= S_OUT;
            S_OUT: if (i_hdr_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_wqe_ready            = (state == S_IDLE) & ~rst;
   assign o_qpc_hdr_lookup_valid = (state == S_LOOKUP);
   assign o_qpc_hdr_lookup_qp_id = qp_id;
   assign o_qpc_hdr_update_valid = (state == S_UPDATE);
   assign o_qpc_hdr_update_qpid  = qp_id;
   assign o_qpc_sq_curr_psn      = new_psn;
   assign o_qpc_sq_curr_msn      = new_msn;
   assign o_hdr_valid            = (state == S_OUT);
   assign o_hdr_qp_id            = qp_id;
   assign o_hdr_dest_qpid        = dest_qpid;
   assign o_hdr_first_psn        = psn;
   assign o_hdr_pkt_cnt          = pkt_cnt;
   assign o_hdr_msn              = msn;
   assign o_hdr_err              = err;

endmodule

// File: tb/tb_tx_qpc_requester.sv
// Directed bench for tx_qpc_requester: hand-computed headers, PSN/MSN
// write-back, handshake stalls, latency, reset abandonment and lookup timeout.
module tb_tx_qpc_requester;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wqe_valid = 1'b0;
   logic        wqe_ready;
   logic [7:0]  wqe_qp_id = '0;
   logic [31:0] wqe_len = '0;
   logic        lk_valid;
   logic        lk_ready = 1'b0;
   logic [7:0]  lk_qp;
   logic        qpc_valid = 1'b0;
   logic [2:0]  qpc_pmtu = '0;
   logic [23:0] qpc_dq = '0;
   logic [23:0] qpc_psn = '0;
   logic [23:0] qpc_msn = '0;
   logic        upd_valid;
   logic [7:0]  upd_qp;
   logic [23:0] upd_psn_o;
   logic [23:0] upd_msn_o;
   logic        hdr_valid;
   logic        hdr_ready = 1'b0;
   logic [7:0]  hdr_qp;
   logic [23:0] hdr_dq;
   logic [23:0] hdr_fpsn;
   logic [24:0] hdr_cnt;
   logic [23:0] hdr_msn;
   logic [1:0]  hdr_err;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int upd_cyc = 0;
   int hdr_cyc = 0;
   int upd_cnt = 0;
   logic        hdr_prev = 1'b0;
   logic [23:0] upd_psn = '0;
   logic [23:0] upd_msn = '0;
   logic [7:0]  upd_qp_s = '0;

   tx_qpc_requester dut (
      .clk(clk), .rst(rst),
      .i_wqe_valid(wqe_valid), .o_wqe_ready(wqe_ready),
      .i_wqe_qp_id(wqe_qp_id), .i_wqe_len(wqe_len),
      .o_qpc_hdr_lookup_valid(lk_valid),
      .i_qpc_hdr_lookup_ready(lk_ready),
      .o_qpc_hdr_lookup_qp_id(lk_qp),
      .i_qpc_valid(qpc_valid), .i_qpc_pmtu(qpc_pmtu),
      .i_qpc_dest_qpid(qpc_dq),
      .i_qpc_sq_curr_psn(qpc_psn), .i_qpc_sq_curr_msn(qpc_msn),
      .o_qpc_hdr_update_valid(upd_valid),
      .o_qpc_hdr_update_qpid(upd_qp),
      .o_qpc_sq_curr_psn(upd_psn_o), .o_qpc_sq_curr_msn(upd_msn_o),
      .o_hdr_valid(hdr_valid), .i_hdr_ready(hdr_ready),
      .o_hdr_qp_id(hdr_qp), .o_hdr_dest_qpid(hdr_dq),
      .o_hdr_first_psn(hdr_fpsn), .o_hdr_pkt_cnt(hdr_cnt),
      .o_hdr_msn(hdr_msn), .o_hdr_err(hdr_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wqe_valid && wqe_ready) hs_cyc <= cyc;
      if (upd_valid) begin
         upd_cnt  <= upd_cnt + 1;
         upd_cyc  <= cyc;
         upd_psn  <= upd_psn_o;
         upd_msn  <= upd_msn_o;
         upd_qp_s <= upd_qp;
      end
      hdr_prev <= hdr_valid;
      if (hdr_valid && !hdr_prev) hdr_cyc <= cyc;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic txn(
      input logic [7:0]  qp,   input logic [31:0] ln,
      input logic [2:0]  pm,   input logic [23:0] dq,
      input logic [23:0] ps,   input logic [23:0] ms,
      input int          lks,  input int          hds,
      input bit          give,
      input logic [24:0] e_cnt, input logic [1:0]  e_err,
      input logic [23:0] e_fpsn, input logic [23:0] e_msn,
      input logic [23:0] e_dq,  input bit          e_upd,
      input logic [23:0] e_npsn, input logic [23:0] e_nmsn);
      int u0;
      int n;
      u0 = upd_cnt;
      @(negedge clk);
      check("wqe_rdy", 32'(wqe_ready), 32'd1);
      wqe_valid = 1'b1;
      wqe_qp_id = qp;
      wqe_len   = ln;
      lk_ready  = (lks == 0);
      @(negedge clk);
      wqe_valid = 1'b0;
      wqe_len   = '0;
      for (int i = 0; i < lks; i++) begin
         check("lk_hold", {23'd0, lk_valid, lk_qp}, {23'd0, 1'b1, qp});
         @(negedge clk);
      end
      lk_ready = 1'b1;
      check("lk_vld", 32'(lk_valid), 32'd1);
      check("lk_qp", 32'(lk_qp), 32'(qp));
      @(negedge clk);
      lk_ready = 1'b0;
      if (give) begin
         qpc_valid = 1'b1;
         qpc_pmtu  = pm;
         qpc_dq    = dq;
         qpc_psn   = ps;
         qpc_msn   = ms;
         @(negedge clk);
         qpc_valid = 1'b0;
      end
      n = 0;
      while (!hdr_valid && n < 80) begin
         @(negedge clk);
         n++;
      end
      check("hdr_vld", 32'(hdr_valid), 32'd1);
      for (int i = 0; i <= hds; i++) begin
         check("hdr_qp", 32'(hdr_qp), 32'(qp));
         check("hdr_dq", 32'(hdr_dq), 32'(e_dq));
         check("hdr_fpsn", 32'(hdr_fpsn), 32'(e_fpsn));
         check("hdr_cnt", 32'(hdr_cnt), 32'(e_cnt));
         check("hdr_msn", 32'(hdr_msn), 32'(e_msn));
         check("hdr_err", 32'(hdr_err), 32'(e_err));
         if (i < hds) @(negedge clk);
      end
      hdr_ready = 1'b1;
      @(negedge clk);
      hdr_ready = 1'b0;
      check("rdy_after", 32'(wqe_ready), 32'd1);
      check("upd_cnt", 32'(upd_cnt - u0), e_upd ? 32'd1 : 32'd0);
      if (e_upd) begin
         check("upd_qp", 32'(upd_qp_s), 32'(qp));
         check("upd_psn", 32'(upd_psn), 32'(e_npsn));
         check("upd_msn", 32'(upd_msn), 32'(e_nmsn));
      end
   endtask

   task automatic chk_reset_outs();
      check("rst_rdy", 32'(wqe_ready), 32'd0);
      check("rst_lk", {24'd0, lk_valid, lk_qp[6:0]}, 32'd0);
      check("rst_upd", {7'd0, upd_valid, upd_psn_o}, 32'd0);
      check("rst_umsn", 32'(upd_msn_o), 32'd0);
      check("rst_hv", {7'd0, hdr_valid, hdr_fpsn}, 32'd0);
      check("rst_hcnt", {5'd0, hdr_err, hdr_cnt}, 32'd0);
      check("rst_hmsn", {8'd0, hdr_msn}, 32'd0);
   endtask

   initial begin
      int u0;
      @(negedge clk);
      chk_reset_outs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rdy_post_rst", 32'(wqe_ready), 32'd1);

      txn(8'd1, 32'd1000, 3'd2, 24'h0ABCDE, 24'h10, 24'd5, 0, 0, 1'b1,
          25'd2, 2'b00, 24'h10, 24'd5, 24'h0ABCDE, 1'b1, 24'h12, 24'd6);
      check("lat_upd", 32'(upd_cyc - hs_cyc), 32'd4);
      check("lat_hdr", 32'(hdr_cyc - hs_cyc), 32'd5);

      txn(8'd7, 32'd0, 3'd3, 24'h000123, 24'hFFFFFF, 24'hFFFFFF, 0, 0,
          1'b1, 25'd1, 2'b00, 24'hFFFFFF, 24'hFFFFFF, 24'h000123, 1'b1,
          24'h000000, 24'h000000);

      txn(8'd3, 32'd100, 3'd0, 24'h000321, 24'h20, 24'd9, 0, 0, 1'b1,
          25'd0, 2'b01, 24'h20, 24'd9, 24'h000321, 1'b0, 24'd0, 24'd0);

      txn(8'h55, 32'd4096, 3'd5, 24'h00BEEF, 24'h100, 24'h10, 3, 4, 1'b1,
          25'd1, 2'b00, 24'h100, 24'h10, 24'h00BEEF, 1'b1, 24'h101, 24'h11);

      txn(8'hA0, 32'hFFFF_FFFF, 3'd1, 24'h111111, 24'd5, 24'd0, 0, 0,
          1'b1, 25'h100_0000, 2'b00, 24'd5, 24'd0, 24'h111111, 1'b1,
          24'd5, 24'd1);

      txn(8'h0C, 32'd64, 3'd7, 24'h222222, 24'h30, 24'h31, 0, 0, 1'b1,
          25'd0, 2'b01, 24'h30, 24'h31, 24'h222222, 1'b0, 24'd0, 24'd0);

      txn(8'hFF, 32'd4097, 3'd4, 24'h333333, 24'hFFFFFE, 24'd7, 0, 0,
          1'b1, 25'd3, 2'b00, 24'hFFFFFE, 24'd7, 24'h333333, 1'b1,
          24'h000001, 24'd8);

      // abandon a request while it sits in WAIT
      u0 = upd_cnt;
      @(negedge clk);
      wqe_valid = 1'b1;
      wqe_qp_id = 8'd9;
      wqe_len   = 32'd500;
      lk_ready  = 1'b1;
      @(negedge clk);
      wqe_valid = 1'b0;
      @(negedge clk);
      lk_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_outs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rdy_after_rst", 32'(wqe_ready), 32'd1);
      repeat (3) @(negedge clk);
      check("rst_no_upd", 32'(upd_cnt - u0), 32'd0);
      check("rst_no_hdr", 32'(hdr_valid), 32'd0);

      txn(8'd2, 32'd256, 3'd1, 24'h444444, 24'h40, 24'd3, 0, 0, 1'b1,
          25'd1, 2'b00, 24'h40, 24'd3, 24'h444444, 1'b1, 24'h41, 24'd4);

`ifdef QPC_LOOKUP_TIMEOUT_EN
      txn(8'd4, 32'd2000, 3'd2, 24'h0, 24'h0, 24'h0, 0, 0, 1'b0,
          25'd0, 2'b10, 24'd0, 24'd0, 24'd0, 1'b0, 24'd0, 24'd0);
      check("lat_tmo", 32'(hdr_cyc - hs_cyc), 32'd34);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
